pwm_fade_seq: RTL and testbench

- Duty-word sequencer that sits directly upstream of the 4-bit PWM stage and drives its `w` input.
- Produces a "breathing" envelope: ramp up to full scale, hold, ramp down to zero, hold.
- Runs either one-shot or continuous; rate and dwell are run-time programmable.
- Typical use is LED fade/breathe effects; the duty output connects straight to the PWM duty input.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_fade_seq_tick_gen.sv | 34 +++
 rtl/pwm_fade_seq.sv | 140 ++++++++++++++
 tb/tb_pwm_fade_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade sequencer: state encoding,
// default widths and the full-scale duty derivation.
package pwm_pkg;

  localparam int DEF_W      = 4;
  localparam int DEF_DIV_W  = 16;
  localparam int DEF_HOLD_W = 8;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RAMP_UP   = 3'd1;
  localparam logic [2:0] S_HOLD_HI   = 3'd2;
  localparam logic [2:0] S_RAMP_DOWN = 3'd3;
  localparam logic [2:0] S_HOLD_LO   = 3'd4;

  // Full-scale duty word for a given duty width.
  function automatic int duty_max_of(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pwm_fade_seq_tick_gen.sv
// Step-interval prescaler: while enabled, emits a one-cycle tick every
// div+1 clocks. The count restarts from zero on clear or when disabled,
// so the first tick after a clear lands div+1 clocks later.
module tick_gen
  import pwm_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == div);

  // Prescaler count: clears on request, when idle, or after each tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/pwm_fade_seq.sv
// Breathing-envelope duty sequencer feeding the PWM duty input:
// ramp up to full scale, dwell, ramp down to zero, dwell; one-shot or
// continuous. Rate, dwell and mode are captured when a run starts.
module pwm_fade_seq
  import pwm_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int DIV_W  = DEF_DIV_W,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              start,
  input  logic              continuous,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [HOLD_W-1:0] hold_ticks,
  output logic [W-1:0]      duty,
  output logic              busy,
  output logic              done
);

  localparam logic [W-1:0]      DUTY_MAX = W'(duty_max_of(W));
  localparam logic [W-1:0]      DUTY_ONE = W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [2:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DIV_W-1:0]  step_div_q;
  logic [HOLD_W-1:0] hold_q;
  logic              cont_q;
  logic              tick;
  logic              start_acc;
  logic [W-1:0]      duty_up;
  logic [W-1:0]      duty_dn;

  // Saturating step towards full scale.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] d);
    return (d == DUTY_MAX) ? DUTY_MAX : d + DUTY_ONE;
  endfunction

  // Saturating step towards zero.
  function automatic logic [W-1:0] sat_dec(input logic [W-1:0] d);
    return (d == '0) ? '0 : d - DUTY_ONE;
  endfunction

  assign start_acc = (state == S_IDLE) && start && enable;
  assign duty_up   = sat_inc(duty);
  assign duty_dn   = sat_dec(duty);

  tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (busy),
    .clr     (start_acc || !enable),
    .div     (step_div_q),
    .tick    (tick)
  );

  // Envelope FSM with duty register, dwell counter and captured config;
  // abort via enable outranks ticks and starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      duty       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hold_cnt   <= '0;
      step_div_q <= '0;
      hold_q     <= '0;
      cont_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!enable) begin
        state <= S_IDLE;
        duty  <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              step_div_q <= step_div;
              hold_q     <= hold_ticks;
              cont_q     <= continuous;
              state      <= S_RAMP_UP;
              busy       <= 1'b1;
            end
          end
          S_RAMP_UP: begin
            if (tick) begin
              duty <= duty_up;
              if (duty_up == DUTY_MAX) begin
                state    <= S_HOLD_HI;
                hold_cnt <= hold_q;
              end
            end
          end
          S_HOLD_HI: begin
            if (tick) begin
              if (hold_cnt == '0) begin
                state <= S_RAMP_DOWN;
              end else begin
                hold_cnt <= hold_cnt - HOLD_ONE;
              end
            end
          end
          S_RAMP_DOWN: begin
            if (tick) begin
              duty <= duty_dn;
              if (duty_dn == '0) begin
                state    <= S_HOLD_LO;
                hold_cnt <= hold_q;
              end
            end
          end
          S_HOLD_LO: begin
            if (tick) begin
              if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_ONE;
              end else if (cont_q) begin
                state <= S_RAMP_UP;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_seq.sv
// Self-checking bench for pwm_fade_seq: directed runs plus randomized
// rates, dwells and mid-run input noise, checked against an envelope
// model computed from tick counts.
module tb_pwm_fade_seq;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        start;
  logic        continuous;
  logic [15:0] step_div;
  logic [7:0]  hold_ticks;
  logic [3:0]  duty;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_err;

  pwm_fade_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .start      (start),
    .continuous (continuous),
    .step_div   (step_div),
    .hold_ticks (hold_ticks),
    .duty       (duty),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Duty after t ticks of one envelope with dwell h (h+1 ticks per extreme).
  function automatic int env(input int t, input int h);
    if (t <= 15) return t;
    if (t <= 16 + h) return 15;
    if (t <= 31 + h) return 31 + h - t;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int ed, input int eb, input int edn);
    chk({tag, " duty"}, {28'b0, duty}, ed);
    chk({tag, " busy"}, {31'b0, busy}, eb);
    chk({tag, " done"}, {31'b0, done}, edn);
  endtask

  // One run from idle. mode 0: clean; 1: start pulse + step_div=7 mid ramp-up;
  // 2: random start pulses and config noise while busy.
  task automatic run_env(input int div, input int hold, input int cont,
                         input int periods, input int mode);
    int p;
    int n;
    int total;
    int t;
    p = div + 1;
    n = 32 + 2 * hold;
    total = cont ? periods * n * p : n * p + 3;
    step_div   = 16'(div);
    hold_ticks = 8'(hold);
    continuous = cont[0];
    start      = 1'b1;
    edge_step();
    start = 1'b0;
    for (int e = 1; e <= total; e++) begin
      if (mode == 1) begin
        start = (e == 5);
        if (e == 5) step_div = 16'd7;
      end else if (mode == 2) begin
        start      = (cont != 0 || e + 1 <= n * p) ? 1'($urandom_range(0, 1)) : 1'b0;
        step_div   = 16'($urandom);
        hold_ticks = 8'($urandom);
        continuous = 1'($urandom_range(0, 1));
      end
      edge_step();
      t = e / p;
      if (cont != 0) begin
        chk_out($sformatf("cont d%0d h%0d e%0d", div, hold, e), env(t % n, hold), 1, 0);
      end else if (e < n * p) begin
        chk_out($sformatf("shot d%0d h%0d e%0d", div, hold, e), env(t, hold), 1, 0);
      end else begin
        chk_out($sformatf("end d%0d h%0d e%0d", div, hold, e), 0, 0, (e == n * p) ? 1 : 0);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n    = 1'b0;
    enable     = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    step_div   = '0;
    hold_ticks = '0;

    // Reset held over random inputs.
    for (int i = 0; i < 6; i++) begin
      enable     = 1'($urandom_range(0, 1));
      start      = 1'($urandom_range(0, 1));
      continuous = 1'($urandom_range(0, 1));
      step_div   = 16'($urandom);
      hold_ticks = 8'($urandom);
      edge_step();
      chk_out($sformatf("rst %0d", i), 0, 0, 0);
    end
    enable  = 1'b1;
    start   = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edge_step();
      chk_out($sformatf("idle %0d", i), 0, 0, 0);
    end

    // One-shot fast run.
    run_env(0, 0, 0, 1, 0);
    // Slow run.
    run_env(3, 2, 0, 1, 0);
    // Ignored start and frozen config mid ramp-up.
    run_env(0, 0, 0, 1, 1);
    // Continuous run, three periods.
    run_env(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1, 3, 0);
    enable = 1'b0;
    edge_step();
    chk_out("cont stop", 0, 0, 0);
    enable = 1'b1;

    // Abort in ramp-down at duty 9 (div=1, hold=1: tick 23, edge 46).
    step_div   = 16'd1;
    hold_ticks = 8'd1;
    continuous = 1'b0;
    start      = 1'b1;
    edge_step();
    start = 1'b0;
    for (int e = 1; e <= 46; e++) begin
      edge_step();
      chk_out($sformatf("pre-abort e%0d", e), env(e / 2, 1), 1, 0);
    end
    enable = 1'b0;
    edge_step();
    chk_out("abort", 0, 0, 0);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edge_step();
      chk_out($sformatf("post-abort %0d", i), 0, 0, 0);
    end
    run_env(0, 0, 0, 1, 0);

    // Asynchronous reset mid-run, then a clean restart.
    step_div   = 16'd0;
    hold_ticks = 8'd0;
    continuous = 1'b1;
    start      = 1'b1;
    edge_step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) edge_step();
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async rst", 0, 0, 0);
    edge_step();
    chk_out("rst held", 0, 0, 0);
    reset_n = 1'b1;
    edge_step();
    chk_out("rst released", 0, 0, 0);
    run_env(0, 0, 0, 1, 0);

    // Randomized one-shot runs with input noise while busy.
    for (int r = 0; r < 4; r++) begin
      run_env(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 1, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
